// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the 8080-style LCD bus controller.
// Covers FSM states, the Avalon register map, status bit positions and the request entry layout.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [1:0] ADDR_CMD  = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;
    localparam logic [1:0] ADDR_RD   = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_RDV     = 4;
    localparam int STAT_CNT_LSB = 8;

    localparam int REQ_W        = 18;
    localparam int REQ_DATA_LSB = 0;
    localparam int REQ_RS_BIT   = 16;
    localparam int REQ_RD_BIT   = 17;

    // Field order matches the bit offsets above: rd at 17, rs at 16, data at 15:0.
    typedef struct packed {
        logic        rd;
        logic        rs;
        logic [15:0] dat;
    } req_t;

    function automatic logic [3:0] phase_load(input int clocks);
        return 4'(clocks - 1);
    endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Synchronous request FIFO with show-ahead pop data.
// Latency: a push appears in count/empty one clock later.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module lcd_req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign pop_dat = mem[rd_ptr];

    // Fullness is judged on the count at the start of the cycle, so a
    // simultaneous pop never makes room for a push into a full FIFO.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// Avalon-MM slave running queued 8080-style write/read cycles on a 16-bit LCD bus.
// Latency: readdata 1 clock; first SETUP clock 2 clocks after a write into an idle block.
// Backpressure: none on Avalon; writes into a full request FIFO are dropped and flag overflow.
module lcd_bus_ctrl
    import lcd_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int T_SETUP    = 1,
    parameter int T_WR_PULSE = 2,
    parameter int T_RD_PULSE = 4,
    parameter int T_HOLD     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    inout  wire  [15:0] bidir_port,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_acc;
    logic          rd_acc;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    req_t          push_req;
    req_t          pop_req;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_nx;
    req_t          cur;
    req_t          cur_nx;
    logic          capture;

    logic          overflow;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic [31:0]   stat;
    logic [31:0]   rd_mux;

    logic          active_nx;
    logic          bus_oe;
    logic [15:0]   bus_out;

    logic          unused_bits;
    assign unused_bits = &{1'b0, writedata[31:17]};

    assign wr_acc = chipselect && !write_n;
    assign rd_acc = chipselect && !read_n;
    assign push   = wr_acc && (address != ADDR_STAT);

    always_comb begin
        push_req     = '0;
        push_req.rd  = (address == ADDR_RD);
        push_req.rs  = (address == ADDR_RD) ? writedata[16] : (address == ADDR_DATA);
        push_req.dat = writedata[15:0];
    end

    lcd_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_req),
        .pop      (pop),
        .pop_dat  (pop_req),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // GAP may pop directly so back-to-back entries see exactly one CS-high clock.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_q;
        cur_nx   = cur;
        pop      = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE, ST_GAP: begin
                if (!empty) begin
                    pop      = 1'b1;
                    cur_nx   = pop_req;
                    state_nx = ST_SETUP;
                    cnt_nx   = phase_load(T_SETUP);
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_nx = ST_PULSE;
                    cnt_nx   = cur.rd ? phase_load(T_RD_PULSE) : phase_load(T_WR_PULSE);
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    capture  = cur.rd;
                    state_nx = ST_HOLD;
                    cnt_nx   = phase_load(T_HOLD);
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_nx = ST_GAP;
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign active_nx = (state_nx == ST_SETUP) || (state_nx == ST_PULSE) || (state_nx == ST_HOLD);

    // Pins are registered from the next-state decode so they line up with the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt_q    <= '0;
            cur      <= '0;
            lcd_cs_n <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_wr_n <= 1'b1;
            lcd_rd_n <= 1'b1;
            bus_oe   <= 1'b0;
            bus_out  <= '0;
        end else begin
            state    <= state_nx;
            cnt_q    <= cnt_nx;
            cur      <= cur_nx;
            lcd_cs_n <= !active_nx;
            lcd_rs   <= cur_nx.rs;
            lcd_wr_n <= !((state_nx == ST_PULSE) && !cur_nx.rd);
            lcd_rd_n <= !((state_nx == ST_PULSE) && cur_nx.rd);
            bus_oe   <= active_nx && !cur_nx.rd;
            bus_out  <= cur_nx.dat;
        end
    end

    assign bidir_port = bus_oe ? bus_out : 16'hzzzz;

    // A capture on the same edge as an addr-2 read keeps rd_valid set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end else if (wr_acc && (address == ADDR_STAT) && writedata[STAT_OVF]) begin
                overflow <= 1'b0;
            end
            if (capture) begin
                rd_valid <= 1'b1;
                rd_data  <= bidir_port;
            end else if (rd_acc && (address == ADDR_RD)) begin
                rd_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        stat                          = '0;
        stat[STAT_BUSY]               = (state != ST_IDLE) || !empty;
        stat[STAT_FULL]               = full;
        stat[STAT_EMPTY]              = empty;
        stat[STAT_OVF]                = overflow;
        stat[STAT_RDV]                = rd_valid;
        stat[STAT_CNT_LSB +: CW]      = count;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_RD:   rd_mux = {15'b0, rd_valid, rd_data};
            ADDR_STAT: rd_mux = stat;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: Avalon driver, LCD pin monitor with an expected-transaction queue,
// and a cycle-level occupancy model for the overflow burst.
module tb_lcd_bus_ctrl;

    localparam int DEPTH   = 8;
    localparam int T_SETUP = 1;
    localparam int T_WR    = 2;
    localparam int T_RD    = 4;
    localparam int T_HOLD  = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    wire  [15:0] bidir_port;
    logic        lcd_cs_n;
    logic        lcd_rs;
    logic        lcd_wr_n;
    logic        lcd_rd_n;
    logic [15:0] lcd_val;

    always #5 clk = ~clk;

    // LCD panel model: drives the bus only while RD is low.
    assign bidir_port = lcd_rd_n ? 16'hzzzz : lcd_val;

    lcd_bus_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .T_SETUP    (T_SETUP),
        .T_WR_PULSE (T_WR),
        .T_RD_PULSE (T_RD),
        .T_HOLD     (T_HOLD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .bidir_port (bidir_port),
        .lcd_cs_n   (lcd_cs_n),
        .lcd_rs     (lcd_rs),
        .lcd_wr_n   (lcd_wr_n),
        .lcd_rd_n   (lcd_rd_n)
    );

    typedef struct {
        bit        rd;
        bit        rs;
        bit [15:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input bit rd, input bit rs, input bit [15:0] d);
        exp_t e;
        e.rd  = rd;
        e.rs  = rs;
        e.dat = d;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor: one record per CS-low window, compared against the queue head.
    bit          in_txn = 0;
    bit          has_exp = 0;
    exp_t        cur_exp;
    int          cs_len, wr_len, rd_len, gap = 0, n_txn = 0, both_low = 0;
    bit          rs0;
    logic [15:0] wdata;
    int          txn_start [64];
    int          txn_gap   [64];

    always @(negedge clk) begin
        if (!reset_n) begin
            in_txn = 0;
            gap    = 0;
        end else begin
            if (!lcd_wr_n && !lcd_rd_n) both_low++;
            if (!lcd_cs_n) begin
                if (!in_txn) begin
                    in_txn = 1;
                    cs_len = 0;
                    wr_len = 0;
                    rd_len = 0;
                    rs0    = lcd_rs;
                    wdata  = '0;
                    txn_start[n_txn % 64] = cyc;
                    txn_gap[n_txn % 64]   = gap;
                    if (exp_q.size() > 0) begin
                        cur_exp = exp_q.pop_front();
                        has_exp = 1;
                        lcd_val = cur_exp.dat;
                    end else begin
                        has_exp = 0;
                    end
                end
                cs_len++;
                if (!lcd_wr_n) begin
                    wr_len++;
                    wdata = bidir_port;
                end
                if (!lcd_rd_n) rd_len++;
            end else begin
                if (in_txn) begin
                    in_txn = 0;
                    if (!has_exp) begin
                        check("unexpected_txn", 1, 0);
                    end else begin
                        check("txn_rs", 32'(rs0), 32'(cur_exp.rs));
                        check("txn_wr_len", wr_len, cur_exp.rd ? 0 : T_WR);
                        check("txn_rd_len", rd_len, cur_exp.rd ? T_RD : 0);
                        check("txn_cs_len", cs_len, T_SETUP + (cur_exp.rd ? T_RD : T_WR) + T_HOLD);
                        if (!cur_exp.rd) check("txn_wdata", 32'(wdata), 32'(cur_exp.dat));
                    end
                    n_txn++;
                    gap = 0;
                end
                if (gap < 1000) gap++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic wait_txn(input int target, input int budget);
        int k = 0;
        while (n_txn < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_txn < target) check("txn_timeout", n_txn, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [31:0] d;
        logic [15:0] model_rd;
        int          base;
        int          issue;

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        writedata  = '0;
        lcd_val    = '0;
        model_rd   = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Reset state
        check("rst_cs_n", 32'(lcd_cs_n), 1);
        check("rst_wr_n", 32'(lcd_wr_n), 1);
        check("rst_rd_n", 32'(lcd_rd_n), 1);
        check("rst_rs", 32'(lcd_rs), 0);
        check("rst_readdata", readdata, 0);
        av_read(2'd3, r);
        check("rst_status", r, 32'h4);

        // Command then data write, back to back
        base = n_txn;
        exp_q.push_back(mk(0, 0, 16'h0022));
        exp_q.push_back(mk(0, 1, 16'hF800));
        issue = cyc;
        av_write(2'd0, 32'h0000_0022);
        av_write(2'd1, 32'h0000_F800);
        wait_txn(base + 2, 100);
        check("first_setup_latency", txn_start[base % 64] - issue, 2);
        check("b2b_gap", txn_gap[(base + 1) % 64], 1);

        // Single read
        idle(3);
        base = n_txn;
        exp_q.push_back(mk(1, 1, 16'h9325));
        av_write(2'd2, 32'h0001_0000);
        wait_txn(base + 1, 100);
        idle(3);
        model_rd = 16'h9325;
        av_read(2'd3, r);
        check("status_rd_valid", r, 32'h14);
        av_read(2'd2, r);
        check("rd_first", r, 32'h0001_9325);
        av_read(2'd2, r);
        check("rd_second", r, 32'h0000_9325);

        // Randomised mixed request rounds; round 0 is write, read, write
        for (int rnd = 0; rnd < 5; rnd++) begin
            int n;
            bit had_rd;
            n      = (rnd == 0) ? 3 : int'($urandom_range(2, 6));
            had_rd = 0;
            base   = n_txn;
            for (int i = 0; i < n; i++) begin
                int typ;
                typ = (rnd == 0) ? ((i == 1) ? 2 : (i == 0 ? 0 : 1)) : int'($urandom_range(0, 2));
                d   = $urandom;
                if (typ == 2) begin
                    exp_q.push_back(mk(1, d[16], d[15:0]));
                    had_rd   = 1;
                    model_rd = d[15:0];
                end else begin
                    exp_q.push_back(mk(0, typ == 1, d[15:0]));
                end
                av_write(2'(typ), d);
            end
            wait_txn(base + n, 40 * n + 40);
            idle(3);
            av_read(2'd2, r);
            check("round_rd_data", r, {15'b0, had_rd, model_rd});
            av_read(2'd3, r);
            check("round_status", r, 32'h4);
        end

        // Overflow burst: occupancy model decides which pushes land
        begin
            int occ, next_pop, n_acc, occ_end;
            bit pop_now, acc;
            bit acc_v [12];
            occ      = 0;
            next_pop = 0;
            n_acc    = 0;
            for (int e = 0; e < 12; e++) begin
                pop_now  = (occ > 0) && (e >= next_pop);
                acc      = (occ < DEPTH);
                acc_v[e] = acc;
                if (acc) n_acc++;
                if (pop_now) next_pop = e + T_SETUP + T_WR + T_HOLD + 1;
                occ = occ + int'(acc) - int'(pop_now);
            end
            occ_end = occ;
            for (int e = 0; e < 12; e++) begin
                if (acc_v[e]) exp_q.push_back(mk(0, 1, 16'hA000 + 16'(e)));
            end
            base = n_txn;
            for (int e = 0; e < 12; e++) begin
                av_write(2'd1, 32'hA000 + 32'(e));
            end
            av_read(2'd3, r);
            check("ovf_bit", 32'(r[3]), 32'(n_acc < 12));
            check("ovf_count", 32'(r[12:8]), occ_end);
            check("ovf_full", 32'(r[1]), 32'(occ_end == DEPTH));
            wait_txn(base + n_acc, 400);
            idle(20);
            check("ovf_txn_count", n_txn - base, n_acc);
            check("ovf_exp_left", exp_q.size(), 0);
            av_read(2'd3, r);
            check("ovf_sticky", r, 32'h0C);
            av_write(2'd3, 32'h8);
            av_read(2'd3, r);
            check("ovf_cleared", r, 32'h4);
        end

        // Reset asserted during a write strobe with more entries queued
        begin
            bit found;
            base  = n_txn;
            found = 0;
            exp_q.push_back(mk(0, 1, 16'h1111));
            exp_q.push_back(mk(0, 1, 16'h2222));
            exp_q.push_back(mk(0, 0, 16'h3333));
            av_write(2'd1, 32'h1111);
            av_write(2'd1, 32'h2222);
            av_write(2'd0, 32'h3333);
            for (int k = 0; k < 30 && !found; k++) begin
                if (!lcd_wr_n) found = 1;
                else @(negedge clk);
            end
            check("rst_saw_wr_pulse", 32'(found), 1);
            #2 reset_n = 1'b0;
            #1;
            check("midrst_cs_n", 32'(lcd_cs_n), 1);
            check("midrst_wr_n", 32'(lcd_wr_n), 1);
            check("midrst_rd_n", 32'(lcd_rd_n), 1);
            check("midrst_rs", 32'(lcd_rs), 0);
            check("midrst_readdata", readdata, 0);
            exp_q.delete();
            repeat (2) @(negedge clk);
            #2 reset_n = 1'b1;
            idle(30);
            check("midrst_no_txn", n_txn, base);
            av_read(2'd3, r);
            check("midrst_status", r, 32'h4);
            av_read(2'd2, r);
            check("midrst_rd_cleared", r, 0);
        end

        check("strobe_exclusive", both_low, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
